// File: rtl/serial_nibble_receiver.sv
// Serial-to-parallel receiver: reassembles MSB-first words from a strobed bit
// stream and presents them on a one-entry valid/ready buffer with error flags.
module serial_nibble_receiver #(
    parameter int WIDTH = 4,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             SerialIn,
    input  logic             SerialValid,
    input  logic             FrameStart,
    output logic [WIDTH-1:0] DataOut,
    output logic             DataValid,
    input  logic             DataReady,
    output logic             Overrun,
    output logic             FrameError,
    output logic [CW-1:0]    BitCount
);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] shifted;
    logic             consume;
    logic             last_bit;

    always_comb begin
        shifted  = {acc[WIDTH-2:0], SerialIn};
        consume  = DataValid && DataReady;
        last_bit = SerialValid && !FrameStart && (state == RECV) &&
                   (BitCount == CW'(WIDTH - 1));
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            acc        <= '0;
            DataOut    <= '0;
            DataValid  <= 1'b0;
            Overrun    <= 1'b0;
            FrameError <= 1'b0;
            BitCount   <= '0;
        end else begin
            FrameError <= 1'b0;
            if (consume) begin
                DataValid <= 1'b0;
            end
            if (SerialValid) begin
                case (state)
                    IDLE: begin
                        if (FrameStart) begin
                            acc      <= WIDTH'(SerialIn);
                            BitCount <= CW'(1);
                            state    <= RECV;
                        end
                    end
                    RECV: begin
                        if (FrameStart) begin
                            FrameError <= 1'b1;
                            acc        <= WIDTH'(SerialIn);
                            BitCount   <= CW'(1);
                        end else if (last_bit) begin
                            acc      <= '0;
                            BitCount <= '0;
                            state    <= IDLE;
                            // A word consumed on this same edge frees the slot.
                            if (!DataValid || consume) begin
                                DataOut   <= shifted;
                                DataValid <= 1'b1;
                            end else begin
                                Overrun <= 1'b1;
                            end
                        end else begin
                            acc      <= shifted;
                            BitCount <= BitCount + CW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_nibble_receiver.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a word-level behavioural model.
module tb_serial_nibble_receiver;

    localparam int W = 4;

    logic         Clk;
    logic         Reset;
    logic         SerialIn;
    logic         SerialValid;
    logic         FrameStart;
    logic [W-1:0] DataOut;
    logic         DataValid;
    logic         DataReady;
    logic         Overrun;
    logic         FrameError;
    logic [2:0]   BitCount;

    int total = 0;
    int bad = 0;

    serial_nibble_receiver #(.WIDTH(W)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .SerialIn(SerialIn),
        .SerialValid(SerialValid),
        .FrameStart(FrameStart),
        .DataOut(DataOut),
        .DataValid(DataValid),
        .DataReady(DataReady),
        .Overrun(Overrun),
        .FrameError(FrameError),
        .BitCount(BitCount)
    );

    initial begin
        Clk = 0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Word-level model: partial word kept as an integer and a bit count
    int m_part = 0;
    int m_n = 0;
    int m_out = 0;
    bit m_valid = 0;
    bit m_ovr = 0;
    bit m_fe = 0;
    bit model_ok = 0;

    always @(posedge Clk) begin
        bit take;
        bit loaded;
        if (Reset) begin
            m_part = 0; m_n = 0; m_out = 0; m_valid = 0; m_ovr = 0; m_fe = 0;
            model_ok = 1;
        end else begin
            take = m_valid && DataReady;
            loaded = 0;
            m_fe = 0;
            if (SerialValid) begin
                if (FrameStart) begin
                    if (m_n > 0) m_fe = 1;
                    m_part = int'(SerialIn);
                    m_n = 1;
                end else if (m_n > 0) begin
                    m_part = m_part * 2 + int'(SerialIn);
                    m_n++;
                    if (m_n == W) begin
                        m_n = 0;
                        if (!m_valid || take) begin
                            m_out = m_part % (1 << W);
                            loaded = 1;
                        end else begin
                            m_ovr = 1;
                        end
                    end
                end
            end
            if (loaded) m_valid = 1;
            else if (take) m_valid = 0;
        end
    end

    always @(negedge Clk) begin
        if (model_ok) begin
            check("model_dataout", 32'(DataOut), 32'(m_out));
            check("model_datavalid", 32'(DataValid), 32'(m_valid));
            check("model_overrun", 32'(Overrun), 32'(m_ovr));
            check("model_frameerror", 32'(FrameError), 32'(m_fe));
            check("model_bitcount", 32'(BitCount), 32'(m_n));
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic send_bit(logic b, logic fs);
        SerialValid = 1; SerialIn = b; FrameStart = fs;
        tick();
        SerialValid = 0; SerialIn = 0; FrameStart = 0;
    endtask

    task automatic do_reset();
        Reset = 1;
        tick();
        Reset = 0;
    endtask

    initial begin
        Reset = 1; SerialIn = 0; SerialValid = 0; FrameStart = 0; DataReady = 0;
        tick();
        Reset = 0;
        check("reset_dataout", 32'(DataOut), 0);
        check("reset_valid", 32'(DataValid), 0);
        check("reset_overrun", 32'(Overrun), 0);
        check("reset_fe", 32'(FrameError), 0);
        check("reset_bitcount", 32'(BitCount), 0);

        // Single word 1011
        DataReady = 1;
        send_bit(1, 1); check("single_bc1", 32'(BitCount), 1);
        send_bit(0, 0); check("single_bc2", 32'(BitCount), 2);
        send_bit(1, 0); check("single_bc3", 32'(BitCount), 3);
        send_bit(1, 0); check("single_bc0", 32'(BitCount), 0);
        check("single_data", 32'(DataOut), 32'hB);
        check("single_valid", 32'(DataValid), 1);
        tick();
        check("single_consumed", 32'(DataValid), 0);

        // Gapped word
        send_bit(1, 1); send_bit(0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("gap_bc_hold", 32'(BitCount), 2);
        end
        send_bit(1, 0); send_bit(1, 0);
        check("gap_data", 32'(DataOut), 32'hB);
        check("gap_valid", 32'(DataValid), 1);
        tick();

        // Overrun: 5 then A with no consumer
        DataReady = 0;
        send_bit(0, 1); send_bit(1, 0); send_bit(0, 0); send_bit(1, 0);
        send_bit(1, 1); send_bit(0, 0); send_bit(1, 0); send_bit(0, 0);
        check("ovr_data", 32'(DataOut), 32'h5);
        check("ovr_flag", 32'(Overrun), 1);
        DataReady = 1;
        tick();
        check("ovr_drain_valid", 32'(DataValid), 0);
        check("ovr_sticky", 32'(Overrun), 1);
        do_reset();

        // Simultaneous consume and complete: 3 buffered, C completes
        DataReady = 0;
        send_bit(0, 1); send_bit(0, 0); send_bit(1, 0); send_bit(1, 0);
        check("sim_first", 32'(DataOut), 32'h3);
        send_bit(1, 1); send_bit(1, 0); send_bit(0, 0);
        DataReady = 1;
        send_bit(0, 0);
        check("sim_data", 32'(DataOut), 32'hC);
        check("sim_valid", 32'(DataValid), 1);
        check("sim_overrun", 32'(Overrun), 0);
        tick();

        // Early FrameStart
        send_bit(1, 1); send_bit(1, 0);
        send_bit(0, 1);
        check("early_fe_pulse", 32'(FrameError), 1);
        send_bit(1, 0);
        check("early_fe_clear", 32'(FrameError), 0);
        send_bit(1, 0); send_bit(0, 0);
        check("early_data", 32'(DataOut), 32'h6);
        tick();

        // Reset mid-word then 9
        send_bit(1, 1); send_bit(0, 0);
        do_reset();
        check("rst_bc", 32'(BitCount), 0);
        send_bit(1, 1); send_bit(0, 0); send_bit(0, 0); send_bit(1, 0);
        check("rst_data", 32'(DataOut), 32'h9);
        check("rst_fe", 32'(FrameError), 0);
        check("rst_ovr", 32'(Overrun), 0);
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            Reset       = ($urandom_range(0, 299) == 0);
            SerialValid = ($urandom_range(0, 3) != 0);
            SerialIn    = 1'($urandom_range(0, 1));
            FrameStart  = ($urandom_range(0, 7) == 0);
            DataReady   = ($urandom_range(0, 2) == 0);
            tick();
        end
        Reset = 0; SerialValid = 0; FrameStart = 0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_nibble_receiver.md
# serial_nibble_receiver

Serial-to-parallel receiver sitting directly downstream of the 4-bit parallel-load shift register. It consumes that register's MSB-first `ShiftOut` bit stream, with a per-bit valid strobe and a frame-start marker, and reassembles complete words. Each word is presented on a one-entry valid/ready output buffer. Overrun and framing errors are flagged for the controlling logic.

## Interface
- `WIDTH`, default 4: word width in bits; legal range 2..16.
- `Clk`  in  1: rising-edge clock.
- `Reset`  in  1: synchronous, active-high reset.
- `SerialIn`  in  1: serial data bit; MSB of each word arrives first.
- `SerialValid`  in  1: `SerialIn` is sampled on this edge only when high.
- `FrameStart`  in  1: qualifies a valid bit as the first (MSB) bit of a word; ignored when `SerialValid`=0.
- `DataOut`  out  WIDTH: assembled word; stable while `DataValid`=1.
- `DataValid`  out  1: output buffer holds an unconsumed word.
- `DataReady`  in  1: consumer accepts `DataOut` on an edge where `DataValid`=1 and `DataReady`=1.
- `Overrun`  out  1: sticky; a completed word was dropped because the buffer was full.
- `FrameError`  out  1: one-cycle pulse; a word was aborted by an early `FrameStart`.
- `BitCount`  out  clog2(WIDTH+1): number of bits of the current partial word received.

## Operation
- Reset values:
  - FSM goes to IDLE.
  - `DataOut` = 0, `DataValid` = 0, `Overrun` = 0, `FrameError` = 0, `BitCount` = 0.
  - The internal shift accumulator is cleared.
- FSM states: IDLE, RECV.
- IDLE:
  - Valid bits without `FrameStart` are discarded.
  - `SerialValid`&`FrameStart`: accumulator = {0…, `SerialIn`}, `BitCount` = 1, go to RECV.
- RECV:
  - `SerialValid`&!`FrameStart`: accumulator = {acc[WIDTH-2:0], `SerialIn`}, `BitCount`+1.
  - `SerialValid`&`FrameStart`: the partial word is discarded and `FrameError` pulses. The bit is taken as the MSB of a new word (`BitCount` = 1), and the FSM stays in RECV.
  - When the bit sampled brings the count to WIDTH, the word is complete. The completed word is the accumulator shifted with this final bit. `BitCount` returns to 0 and the FSM goes to IDLE.
- Completion and the output buffer:
  - The completed word is loaded into `DataOut` and `DataValid` is set if the buffer is empty, or if it is being consumed on the same edge (`DataValid`&`DataReady`).
  - Otherwise the completed word is dropped, `Overrun` is set, and `DataOut` is unchanged.
- Consume: `DataValid`&`DataReady` with no simultaneous completion clears `DataValid`; `DataOut` holds its last value.
- `Overrun` clears only on `Reset`.
- Cycles with `SerialValid`=0 change no state except the output handshake; gaps of any length inside a word are legal.
- `Reset` mid-word or with `DataValid`=1 discards all data immediately; no `FrameError` or `Overrun` is generated.
- Reset has priority over all other inputs.

## Timing
- All outputs are registered and update only on the rising edge of `Clk`.
- Latency: if the final bit is sampled on edge N, `DataValid`=1 and the new `DataOut` are visible after edge N.
- Back-to-back rate: one word per WIDTH valid bits. A `FrameStart` bit on the edge immediately after completion is accepted, since the FSM is in IDLE.
- `DataReady` is a pure accept and has no combinational path to any output.
- `FrameError` is high for exactly the cycle after the aborting edge.
- `BitCount` reflects bits received as of the last edge: 0..WIDTH-1, and never reads WIDTH.

## Test plan
- Single word: WIDTH=4, `DataReady`=1. Bits 1,0,1,1 on consecutive edges, with `FrameStart` on the first bit. Required: `DataOut`=4'hB and `DataValid`=1 for one cycle after the 4th edge; `BitCount` steps 1,2,3,0.
- Gapped bits: the same word with `SerialValid` low for 3 cycles between bits 2 and 3. Required: `DataOut`=4'hB; `BitCount` holds at 2 during the gap.
- Overrun: `DataReady`=0; send 4'h5 then 4'hA. Required: `DataOut` stays 4'h5 and `Overrun`=1. Raising `DataReady` then clears `DataValid`, and `Overrun` stays 1.
- Simultaneous consume and complete: `DataValid`=1 with 4'h3, and `DataReady`=1 on the edge that completes 4'hC. Required: `DataOut`=4'hC, `DataValid`=1, `Overrun`=0.
- Early `FrameStart`: bits 1,1 and then `FrameStart` with bits 0,1,1,0. Required: one `FrameError` pulse, `DataOut`=4'h6.
- Reset mid-word: after 2 bits, assert `Reset` for one cycle, then send 4'h9. Required: `BitCount`=0 after reset, then `DataOut`=4'h9, with no error flags.
